// File: rtl/aes_inv_round_if.sv
// rtl/aes_inv_round_if.sv - valid/ready bundle carrying one inverse AES round in and its result out
interface aes_inv_round_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [127:0] in_key;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  modport master (
    output in_valid, in_data, in_key, in_last, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_key, in_last, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/aes_inv_round.sv
// rtl/aes_inv_round.sv - one pipelined AES inverse-cipher round
// InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns (skipped on the last round).
module aes_inv_round #(
  parameter int STAGES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  aes_inv_round_if.slave bus
);

  // Entry 0 sits in the top byte so a lookup is a plain part-select.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [7:0] b [16];
    for (int k = 0; k < 16; k++) b[k] = s[8*(15-k) +: 8];
    return {b[0], b[13], b[10], b[7],  b[4], b[1], b[14], b[11],
            b[8], b[5],  b[2],  b[15], b[12], b[9], b[6], b[3]};
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = inv_sbox(s[8*k +: 8]);
    return r;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m9 [4], mb [4], md [4], me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[8*(3-i) +: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] key_and_mix(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
    logic [127:0] x, r;
    x = s ^ k;
    r = '0;
    for (int c = 0; c < 4; c++) r[32*c +: 32] = inv_mix_col(x[32*c +: 32]);
    return last ? x : r;
  endfunction

  logic         adv;
  logic         mid_valid;
  logic [127:0] mid_state;
  logic [127:0] mid_key;
  logic         mid_last;
  logic         out_valid_q;
  logic [127:0] out_data_q;

  // One global enable: the whole pipe freezes while the output is stalled.
  assign adv           = ~out_valid_q | bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

  generate
    if (STAGES == 2) begin : g_two_stage
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mid_valid <= 1'b0;
          mid_state <= '0;
          mid_key   <= '0;
          mid_last  <= 1'b0;
        end else if (adv) begin
          mid_valid <= bus.in_valid;
          mid_state <= inv_sub_bytes(inv_shift_rows(bus.in_data));
          mid_key   <= bus.in_key;
          mid_last  <= bus.in_last;
        end
      end
    end else begin : g_one_stage
      assign mid_valid = bus.in_valid;
      assign mid_state = inv_sub_bytes(inv_shift_rows(bus.in_data));
      assign mid_key   = bus.in_key;
      assign mid_last  = bus.in_last;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (adv) begin
      out_valid_q <= mid_valid;
      out_data_q  <= key_and_mix(mid_state, mid_key, mid_last);
    end
  end

endmodule

// File: tb/tb_aes_inv_round.sv
// tb/tb_aes_inv_round.sv - directed vectors, pipeline corner cases and random scoreboard for aes_inv_round
module tb_aes_inv_round;
  localparam int STAGES = 2;
  localparam int NRND   = 10000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_inv_round_if bus ();
  aes_inv_round #(.STAGES(STAGES)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  typedef struct {
    logic [127:0] data;
    logic [127:0] key;
    logic         last;
    logic [127:0] exp;
  } vec_t;

  vec_t         vecs [7];
  int           total = 0;
  int           bad   = 0;
  int           cyc   = 0;
  logic [7:0]   inv_tab [256];
  logic         mon_en = 1'b0;
  logic         rnd_en = 1'b0;
  logic         acc_flag = 1'b0;
  logic         hold_valid = 1'b0;
  logic [127:0] hold_data = '0;
  logic [127:0] got_q [$];
  int           got_cyc [$];
  logic [127:0] exp_q [$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: table derived from field inversion + affine map, multiply by shift-and-add.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic build_tab();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      inv_tab[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] d, input logic [127:0] k,
                                         input logic last);
    logic [7:0] s [4][4];
    logic [7:0] t [4][4];
    logic [7:0] m [4];
    logic [7:0] acc;
    logic [127:0] r;
    m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    for (int row = 0; row < 4; row++)
      for (int c = 0; c < 4; c++) s[row][c] = d[127-8*(row+4*c) -: 8];
    for (int row = 0; row < 4; row++)
      for (int c = 0; c < 4; c++) t[row][(c+row)%4] = inv_tab[s[row][c]];
    for (int row = 0; row < 4; row++)
      for (int c = 0; c < 4; c++) t[row][c] = t[row][c] ^ k[127-8*(row+4*c) -: 8];
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(m[(j-row+4)%4], t[j][c]);
        r[127-8*(row+4*c) -: 8] = last ? t[row][c] : acc;
      end
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en && bus.out_valid && bus.out_ready) begin
      got_q.push_back(bus.out_data);
      got_cyc.push_back(cyc);
    end
  end

  always @(negedge clk) begin
    if (rnd_en) begin
      acc_flag <= bus.in_valid && bus.in_ready;
      if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.in_data, bus.in_key, bus.in_last));
      if (hold_valid) begin
        chk("stall valid held", bus.out_valid, 1);
        chk("stall data held", bus.out_data, hold_data);
      end
      hold_valid <= bus.out_valid && !bus.out_ready;
      hold_data  <= bus.out_data;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL random extra output: got %h expected none", bus.out_data);
        end else begin
          chk("random data", bus.out_data, exp_q.pop_front());
        end
      end
    end
  end

  task automatic drive(input vec_t v);
    bus.in_valid = 1'b1;
    bus.in_data  = v.data;
    bus.in_key   = v.key;
    bus.in_last  = v.last;
  endtask

  task automatic run_vec(input int i, input string tag);
    int lat;
    @(posedge clk); #1;
    drive(vecs[i]);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("%s vec%0d latency", tag, i), lat, STAGES);
    chk($sformatf("%s vec%0d data", tag, i), bus.out_data, vecs[i].exp);
  endtask

  initial begin
    int sent, cycles;
    build_tab();
    vecs[0] = '{128'h7ad5fda789ef4e272bca100b3d9ff59f, 128'h549932d1f08557681093ed9cbe2c974e,
                1'b0, 128'h54d990a16ba09ab596bbf40ea111702f};
    vecs[1] = '{128'h6353e08c0960e104cd70b751bacad0e7, 128'h000102030405060708090a0b0c0d0e0f,
                1'b1, 128'h00112233445566778899aabbccddeeff};
    vecs[2] = '{128'h7ad5fda789ef4e272bca100b3d9ff59f, 128'h549932d1f08557681093ed9cbe2c974e,
                1'b1, 128'he9f74eec023020f61bf2ccf2353c21c7};
    vecs[3] = '{128'h0, 128'h0, 1'b0, {16{8'h52}}};
    vecs[4] = '{128'h0, {16{8'hff}}, 1'b1, {16{8'had}}};
    vecs[5] = '{{16{8'h63}}, 128'h0, 1'b0, 128'h0};
    vecs[6] = '{{16{8'h63}}, 128'h000102030405060708090a0b0c0d0e0f,
                1'b1, 128'h000102030405060708090a0b0c0d0e0f};

    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_key = '0; bus.in_last = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("reset out_valid", bus.out_valid, 0);
    chk("reset out_data", bus.out_data, 0);
    chk("reset in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(i, "table");

    // Back-to-back: three blocks, three consecutive outputs.
    @(posedge clk); #1;
    got_q.delete(); got_cyc.delete(); mon_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("b2b in_ready %0d", i), bus.in_ready, 1);
      drive(vecs[(i == 1) ? 1 : 0]);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk); #1;
    mon_en = 1'b0;
    chk("b2b count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      for (int j = 0; j < 3; j++) begin
        chk($sformatf("b2b data %0d", j), got_q[j], vecs[(j == 1) ? 1 : 0].exp);
        chk($sformatf("b2b spacing %0d", j), got_cyc[j] - got_cyc[0], j);
      end
    end

    // Backpressure with a full pipe and a third block waiting.
    got_q.delete(); got_cyc.delete(); mon_en = 1'b1;
    bus.out_ready = 1'b0;
    drive(vecs[0]);
    @(posedge clk); #1;
    drive(vecs[1]);
    @(posedge clk); #1;
    drive(vecs[2]);
    for (int j = 0; j < 5; j++) begin
      chk($sformatf("stall%0d out_valid", j), bus.out_valid, 1);
      chk($sformatf("stall%0d out_data", j), bus.out_data, vecs[0].exp);
      chk($sformatf("stall%0d in_ready", j), bus.in_ready, 0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk); #1;
    mon_en = 1'b0;
    chk("stall release count", got_q.size(), 3);
    if (got_q.size() == 3)
      for (int j = 0; j < 3; j++) chk($sformatf("stall release data %0d", j), got_q[j], vecs[j].exp);

    // Reset with two blocks in flight.
    bus.out_ready = 1'b0;
    drive(vecs[0]);
    @(posedge clk); #1;
    drive(vecs[1]);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("pre-reset out_valid", bus.out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid reset out_valid", bus.out_valid, 0);
    chk("mid reset out_data", bus.out_data, 0);
    chk("mid reset in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    got_q.delete(); got_cyc.delete(); mon_en = 1'b1;
    repeat (4) @(posedge clk); #1;
    mon_en = 1'b0;
    chk("post reset no ghost output", got_q.size(), 0);
    run_vec(0, "post reset");

    // Random traffic against the reference model.
    exp_q.delete();
    sent = 0; cycles = 0;
    @(posedge clk); #1;
    rnd_en = 1'b1;
    while (sent < NRND && cycles < 60000) begin
      @(posedge clk); #1;
      cycles++;
      if (bus.in_valid && acc_flag) sent++;
      if (!bus.in_valid || acc_flag) begin
        if (sent < NRND && $urandom_range(3) != 0) begin
          bus.in_valid = 1'b1;
          bus.in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
          bus.in_key   = {$urandom(), $urandom(), $urandom(), $urandom()};
          bus.in_last  = 1'(($urandom_range(1)));
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      bus.out_ready = ($urandom_range(3) != 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    cycles = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && cycles < 50) begin
      @(posedge clk); #1;
      cycles++;
    end
    rnd_en = 1'b0;
    chk("random sent count", sent, NRND);
    chk("random drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
